// File: rtl/fsqrt_ctrl.sv
// Issue/retire front-end for the pipelined square-root core: credit-gated issue,
// latency-matched tag pipeline and a show-ahead result FIFO. Optional macro FSQRT_SPECIAL_EN.
module fsqrt_ctrl #(
    parameter int LAT   = 3,
    parameter int TAG_W = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      core_x,
    input  logic [31:0]      core_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    // Handshake: a transfer happens at a rising edge where valid and ready are both
    // high; valid never waits on ready, and ready may depend on state only.

    logic [LAT-1:0]   sr_valid;
    logic [TAG_W-1:0] sr_tag     [LAT];
    logic [LAT-1:0]   sr_ovr;
    logic [31:0]      sr_ovr_val [LAT];
    logic [LAT-1:0]   sr_nv;

    logic [31:0]      mem_y   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [DEPTH-1:0] mem_nv;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [SUM_W-1:0] inflight;
    logic [SUM_W-1:0] credit_sum;
    logic             issue;
    logic             push;
    logic             pop;
    logic [31:0]      retire_y;

    logic             cls_ovr;
    logic [31:0]      cls_val;
    logic             cls_nv;

`ifdef FSQRT_SPECIAL_EN
    // Denormals fall into the exponent-zero branch and come back as signed zero.
    always_comb begin
        cls_ovr = 1'b0;
        cls_val = 32'h0;
        cls_nv  = 1'b0;
        if (in_x[30:23] == 8'h00) begin
            cls_ovr = 1'b1;
            cls_val = {in_x[31], 31'h0};
        end else if (in_x[30:23] == 8'hFF && in_x[22:0] != 23'h0) begin
            cls_ovr = 1'b1;
            cls_val = 32'h7FC0_0000;
        end else if (in_x[31]) begin
            cls_ovr = 1'b1;
            cls_val = 32'h7FC0_0000;
            cls_nv  = 1'b1;
        end else if (in_x[30:23] == 8'hFF) begin
            cls_ovr = 1'b1;
            cls_val = 32'h7F80_0000;
        end
    end
`else
    assign cls_ovr = 1'b0;
    assign cls_val = 32'h0;
    assign cls_nv  = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + SUM_W'(sr_valid[k]);
        end
    end

    // Credit ignores a same-cycle pop, so the FIFO can never be pushed while full.
    assign credit_sum = inflight + SUM_W'(count);
    assign in_ready   = !rstn && !flush && (credit_sum < SUM_W'(DEPTH));
    assign issue      = in_valid && in_ready;
    assign core_x     = issue ? in_x : 32'h0;

    assign push     = sr_valid[LAT-1] && !flush;
    assign pop      = out_ready && (count != '0) && !flush;
    assign retire_y = sr_ovr[LAT-1] ? sr_ovr_val[LAT-1] : core_y;

    assign out_valid = (count != '0);
    assign out_y     = mem_y[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
    assign out_nv    = mem_nv[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sr_valid <= '0;
            sr_ovr   <= '0;
            sr_nv    <= '0;
            for (int k = 0; k < LAT; k++) begin
                sr_tag[k]     <= '0;
                sr_ovr_val[k] <= '0;
            end
        end else begin
            sr_valid[0]   <= issue;
            sr_tag[0]     <= in_tag;
            sr_ovr[0]     <= cls_ovr;
            sr_ovr_val[0] <= cls_val;
            sr_nv[0]      <= cls_nv;
            for (int k = 1; k < LAT; k++) begin
                sr_valid[k]   <= sr_valid[k-1] && !flush;
                sr_tag[k]     <= sr_tag[k-1];
                sr_ovr[k]     <= sr_ovr[k-1];
                sr_ovr_val[k] <= sr_ovr_val[k-1];
                sr_nv[k]      <= sr_nv[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem_nv <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_y[i]   <= '0;
                mem_tag[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_y[wr_ptr]   <= retire_y;
                mem_tag[wr_ptr] <= sr_tag[LAT-1];
                mem_nv[wr_ptr]  <= sr_nv[LAT-1];
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/fsqrt_ctrl.md
# fsqrt_ctrl

Issue and retire front-end for the pipelined FPU square-root core. It accepts operand requests over a valid/ready handshake and drives the core's operand input. Each request's destination tag travels through a shift register matched to the core latency. Core results are captured into a show-ahead output FIFO, so the writeback side can backpressure without ever stalling the free-running core.

## Interface
Parameters:
- LAT, 3: fixed latency of the sqrt core, in clock edges from operand to result.
- TAG_W, 6: width of the destination register tag.
- DEPTH, 8: output FIFO entries; must be at least LAT+1, and at least LAT+2 for full throughput.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-high (asserted when 1) despite the name.
- flush  in  1  synchronous kill of all in-flight and buffered results.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted at this edge if in_valid is also high.
- in_x  in  32  IEEE-754 single operand.
- in_tag  in  TAG_W  destination tag.
- core_x  out  32  operand to the sqrt core.
- core_y  in  32  result from the sqrt core.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head at this edge.
- out_y  out  32  result.
- out_tag  out  TAG_W  tag of the result.
- out_nv  out  1  invalid-operation flag of the result.

## Operation
- Issue: fires on in_valid && in_ready. core_x = in_x on issue, else 32'h0.
- Credit: in_ready = !rstn_asserted && !flush && (inflight + count < DEPTH).
  - inflight = popcount of the valid shift register.
  - count = FIFO occupancy.
  - A pop in the same cycle does not return credit; the gating is conservative. This guarantees the FIFO never overflows.
- Shift register of LAT stages, each holding {valid, tag, ovr, ovr_val, nv}.
  - Stage 0 is loaded at the issue edge.
  - Stage k holds the entry issued k edges earlier.
  - An empty issue slot loads valid=0.
- Retire: when stage LAT-1 is valid, the next edge pushes {ovr ? ovr_val : core_y, tag, nv} into the FIFO.
  - core_y is aligned with stage LAT-1 in that cycle.
- FIFO:
  - Circular, with DEPTH entries.
  - Read/write pointers wrap modulo DEPTH.
  - count is held in a log2(DEPTH)+1 bit counter.
  - A push and pop in the same cycle leaves count unchanged and is legal at count=DEPTH-1 or when empty-with-push? No: pop requires count>0, so a push into an empty FIFO becomes visible one cycle later. There is no bypass.
  - out_valid = (count != 0). out_y, out_tag and out_nv read the head entry.
- Flush:
  - At the next edge, all shift-register valid bits are cleared and the FIFO is emptied (pointers and count to 0).
  - Any issue or pop presented in that cycle is ignored.
- Reset mid-operation: all state clears immediately, and in-flight results are discarded.
  - Garbage from the core after reset is ignored because all valid bits are 0.

## Timing
- Reset values: in_ready=0 while rstn=1; out_valid=0, out_y=0, out_tag=0, out_nv=0, core_x=0, all valid bits 0.
- in_ready rises combinationally in the first cycle after rstn deasserts.
- Issue at edge E0: the result is pushed at edge E0+LAT, and out_valid is high after E0+LAT. End-to-end latency is LAT+1 cycles (4 by default).
- Throughput is one result per cycle when out_ready stays high and DEPTH ≥ LAT+2.
- With out_ready low, accepted requests stop once inflight+count reaches DEPTH. All results still land, and none are lost.
- Ordering: results leave in issue order.

## Configuration
- FSQRT_SPECIAL_EN defined: the operand is classified at issue and the override is stored in the shift register.
  - +0 gives +0. -0 gives -0 (0x80000000).
  - +inf gives 0x7F800000.
  - Any NaN gives 0x7FC00000.
  - Negative nonzero (including -inf) gives 0x7FC00000 with nv=1.
  - Denormal inputs are treated as zero of the same sign.
- FSQRT_SPECIAL_EN undefined: ovr=0 and nv=0 always, and core_y passes unmodified.

## Test plan
- Single issue, in_x=0x40800000, tag=5, out_ready=1: core_x=0x40800000 at the issue cycle. out_valid rises exactly 4 cycles later with out_tag=5 and out_y equal to the core model's result for 4.0.
- Back-to-back: 16 issues on consecutive cycles, tags 0..15, out_ready=1: in_ready stays 1, and the tags emerge 0..15 on 16 consecutive cycles.
- Backpressure: out_ready=0 with in_valid held high: in_ready drops after 8 total accepts. count reaches 8 with no overflow. Releasing out_ready drains tags in order and re-opens credit.
- Flush: flush pulsed one cycle with 3 in flight and 2 buffered: out_valid is 0 the next cycle, and nothing emerges in the following LAT cycles.
- Async reset: rstn asserted mid-stream, between edges: outputs are 0 immediately. After release, a new issue with tag 9 returns tag 9 only.
- FSQRT_SPECIAL_EN: inputs 0xC0800000, 0x80000000 and 0x7F800000 give out_y 0x7FC00000 (nv=1), 0x80000000 (nv=0) and 0x7F800000 (nv=0). With the macro undefined, nv stays 0 and core_y passes through.
